// File: rtl/mac_tx_arbiter_if.sv
// Packet-stream bundle between two transmit sources, the arbiter and the
// MAC pkt_tx port. The arbiter connects through the slave modport. The
// sources and the MAC model connect through the master modport.
interface mac_tx_arbiter_if;
    logic [63:0] src0_data;
    logic        src0_sop;
    logic        src0_eop;
    logic [2:0]  src0_mod;
    logic        src0_val;
    logic        src0_rdy;

    logic [63:0] src1_data;
    logic        src1_sop;
    logic        src1_eop;
    logic [2:0]  src1_mod;
    logic        src1_val;
    logic        src1_rdy;

    logic [63:0] pkt_tx_data;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic        pkt_tx_val;
    logic        pkt_tx_full;

    modport slave (
        input  src0_data, src0_sop, src0_eop, src0_mod, src0_val,
        output src0_rdy,
        input  src1_data, src1_sop, src1_eop, src1_mod, src1_val,
        output src1_rdy,
        output pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_val,
        input  pkt_tx_full
    );

    modport master (
        output src0_data, src0_sop, src0_eop, src0_mod, src0_val,
        input  src0_rdy,
        output src1_data, src1_sop, src1_eop, src1_mod, src1_val,
        input  src1_rdy,
        input  pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_val,
        output pkt_tx_full
    );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Packet-atomic round-robin arbiter. Two packet sources share the MAC
// pkt_tx port. A grant lasts from sop to eop. Arbitration takes one bubble
// cycle in IDLE. The pkt_tx_* outputs are registered, so an accepted beat
// reaches the MAC one cycle after it is accepted.
module mac_tx_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25,
    mac_tx_arbiter_if.slave  bus,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        rr_last;      // 0: source 0 owned the last packet, 1: source 1
    logic        first_beat;   // the next accepted beat is the first of the grant
    logic        rdy0, rdy1;
    logic        orphan0, orphan1;
    logic        acc;          // a beat from the granted source is accepted this cycle
    logic        sel1;         // the granted source is source 1
    logic [63:0] sel_data;
    logic        sel_sop, sel_eop;
    logic [2:0]  sel_mod;

    // Add 0, 1 or 2 to a counter. The result clamps at all-ones instead of
    // wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign bus.src0_rdy = rdy0;
    assign bus.src1_rdy = rdy1;

    // Next-state logic, per-source ready, and orphan detection.
    always_comb begin
        // NOTE: default every output of this block first. A path that leaves
        // a signal unassigned would infer a latch.
        state_nxt = state;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        orphan0   = 1'b0;
        orphan1   = 1'b0;
        unique case (state)
            IDLE: begin
                // Beats without sop have no packet to belong to. Accept them
                // and discard them. A request (sop) is never accepted here.
                orphan0 = bus.src0_val & ~bus.src0_sop;
                orphan1 = bus.src1_val & ~bus.src1_sop;
                rdy0    = orphan0;
                rdy1    = orphan1;
                if (bus.src0_val && bus.src0_sop &&
                    (!(bus.src1_val && bus.src1_sop) || rr_last))
                    state_nxt = GNT0;
                else if (bus.src1_val && bus.src1_sop)
                    state_nxt = GNT1;
            end
            GNT0: begin
                rdy0 = ~bus.pkt_tx_full;
                if (bus.src0_val && rdy0 && bus.src0_eop)
                    state_nxt = IDLE;
            end
            GNT1: begin
                rdy1 = ~bus.pkt_tx_full;
                if (bus.src1_val && rdy1 && bus.src1_eop)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select the beat of the granted source and detect its acceptance.
    always_comb begin
        sel1     = (state == GNT1);
        sel_data = sel1 ? bus.src1_data : bus.src0_data;
        sel_sop  = sel1 ? bus.src1_sop  : bus.src0_sop;
        sel_eop  = sel1 ? bus.src1_eop  : bus.src0_eop;
        sel_mod  = sel1 ? bus.src1_mod  : bus.src0_mod;
        acc      = ((state == GNT0) && bus.src0_val && rdy0) ||
                   ((state == GNT1) && bus.src1_val && rdy1);
    end

    // State register, round-robin pointer, and first-beat tracking.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            // NOTE: sequential state uses non-blocking assignments. Every flop
            // then samples values from before the edge, whatever the order of
            // the blocks.
            state      <= IDLE;
            rr_last    <= 1'b1;
            first_beat <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                first_beat <= 1'b1;
            else if (acc)
                first_beat <= 1'b0;
            if (acc && sel_eop)
                rr_last <= sel1;
        end
    end

    // Register the accepted beat toward the MAC. The data fields hold while
    // no beat is accepted.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            bus.pkt_tx_data <= '0;
            bus.pkt_tx_sop  <= 1'b0;
            bus.pkt_tx_eop  <= 1'b0;
            bus.pkt_tx_mod  <= '0;
            bus.pkt_tx_val  <= 1'b0;
        end else begin
            bus.pkt_tx_val <= acc;
            if (acc) begin
                bus.pkt_tx_data <= sel_data;
                bus.pkt_tx_sop  <= sel_sop;
                bus.pkt_tx_eop  <= sel_eop;
                bus.pkt_tx_mod  <= sel_mod;
            end
        end
    end

    // Statistics counters and the sticky protocol-error flag. A clear takes
    // priority over any increment in the same cycle.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
            drop_cnt  <= '0;
            proto_err <= 1'b0;
        end else if (clr_stats) begin
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
            drop_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (acc && sel_eop && !sel1)
                pkt_cnt0 <= sat_add(pkt_cnt0, 2'd1);
            if (acc && sel_eop && sel1)
                pkt_cnt1 <= sat_add(pkt_cnt1, 2'd1);
            if (orphan0 || orphan1)
                drop_cnt <= sat_add(drop_cnt, {1'b0, orphan0} + {1'b0, orphan1});
            if (acc && sel_sop && !first_beat)
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter. The expected values are worked out by
// hand from the arbitration, latency and counter rules.
module tb_mac_tx_arbiter;

    localparam int CNT_W = 16;

    logic             clk_156m25;
    logic             reset_156m25;
    logic             clr_stats;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1, drop_cnt;
    logic             proto_err;

    int n_tests;
    int n_fail;

    mac_tx_arbiter_if bus ();

    mac_tx_arbiter #(.CNT_W(CNT_W)) dut (
        .clk_156m25   (clk_156m25),
        .reset_156m25 (reset_156m25),
        .bus          (bus.slave),
        .clr_stats    (clr_stats),
        .pkt_cnt0     (pkt_cnt0),
        .pkt_cnt1     (pkt_cnt1),
        .drop_cnt     (drop_cnt),
        .proto_err    (proto_err)
    );

    initial clk_156m25 = 1'b0;
    always #5 clk_156m25 = ~clk_156m25;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_156m25);
        #1;
    endtask

    task automatic drive0(input logic val, input logic sop, input logic eop,
                          input logic [2:0] mod, input logic [63:0] data);
        bus.src0_val  = val;
        bus.src0_sop  = sop;
        bus.src0_eop  = eop;
        bus.src0_mod  = mod;
        bus.src0_data = data;
        #1;
    endtask

    task automatic drive1(input logic val, input logic sop, input logic eop,
                          input logic [2:0] mod, input logic [63:0] data);
        bus.src1_val  = val;
        bus.src1_sop  = sop;
        bus.src1_eop  = eop;
        bus.src1_mod  = mod;
        bus.src1_data = data;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [63:0] data,
                             input logic sop, input logic eop, input logic [2:0] mod);
        check({tag, "_val"},  bus.pkt_tx_val,  1'b1);
        check({tag, "_data"}, bus.pkt_tx_data, data);
        check({tag, "_sop"},  bus.pkt_tx_sop,  sop);
        check({tag, "_eop"},  bus.pkt_tx_eop,  eop);
        check({tag, "_mod"},  bus.pkt_tx_mod,  mod);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_156m25    = 1'b1;
        clr_stats       = 1'b0;
        bus.pkt_tx_full = 1'b0;
        drive0(0, 0, 0, 0, 64'h0);
        drive1(0, 0, 0, 0, 64'h0);

        // Reset state.
        check("rst_val",   bus.pkt_tx_val,  1'b0);
        check("rst_data",  bus.pkt_tx_data, 64'h0);
        check("rst_rdy0",  bus.src0_rdy,    1'b0);
        check("rst_rdy1",  bus.src1_rdy,    1'b0);
        check("rst_cnt0",  pkt_cnt0,        16'd0);
        check("rst_drop",  drop_cnt,        16'd0);
        check("rst_perr",  proto_err,       1'b0);
        tick();
        tick();
        reset_156m25 = 1'b0;
        tick();

        // Single 3-beat packet from source 0.
        drive0(1, 1, 0, 0, 64'hA1);
        check("p1_rdy_bubble", bus.src0_rdy, 1'b0);
        tick();
        check("p1_rdy_gnt", bus.src0_rdy,   1'b1);
        check("p1_val_gap", bus.pkt_tx_val, 1'b0);
        tick();
        check_out("p1_b1", 64'hA1, 1, 0, 0);
        drive0(1, 0, 0, 0, 64'hA2);
        tick();
        check_out("p1_b2", 64'hA2, 0, 0, 0);
        drive0(1, 0, 1, 5, 64'hA3);
        tick();
        check_out("p1_b3", 64'hA3, 0, 1, 5);
        check("p1_cnt0", pkt_cnt0, 16'd1);
        drive0(0, 0, 0, 0, 64'h0);
        check("p1_rdy_idle", bus.src0_rdy, 1'b0);
        tick();
        check("p1_val_end",  bus.pkt_tx_val,  1'b0);
        check("p1_data_hold", bus.pkt_tx_data, 64'hA3);

        // Tie after reset: source 0 goes first, then source 1, with no interleaving.
        reset_156m25 = 1'b1;
        #1;
        reset_156m25 = 1'b0;
        tick();
        drive0(1, 1, 0, 0, 64'hB1);
        drive1(1, 1, 0, 0, 64'hC1);
        check("tie_rdy0_bubble", bus.src0_rdy, 1'b0);
        check("tie_rdy1_bubble", bus.src1_rdy, 1'b0);
        tick();
        check("tie_rdy0_gnt", bus.src0_rdy, 1'b1);
        check("tie_rdy1_wait", bus.src1_rdy, 1'b0);
        tick();
        check_out("tie_b1", 64'hB1, 1, 0, 0);
        drive0(1, 0, 1, 0, 64'hB2);
        check("tie_rdy1_held", bus.src1_rdy, 1'b0);
        tick();
        check_out("tie_b2", 64'hB2, 0, 1, 0);
        drive0(0, 0, 0, 0, 64'h0);
        check("tie_rdy1_bubble2", bus.src1_rdy, 1'b0);
        tick();
        check("tie_val_gap", bus.pkt_tx_val, 1'b0);
        check("tie_rdy1_gnt", bus.src1_rdy, 1'b1);
        tick();
        check_out("tie_c1", 64'hC1, 1, 0, 0);
        drive1(1, 0, 1, 3, 64'hC2);
        tick();
        check_out("tie_c2", 64'hC2, 0, 1, 3);
        check("tie_cnt0", pkt_cnt0, 16'd1);
        check("tie_cnt1", pkt_cnt1, 16'd1);

        // The next tie goes to source 0 again. Its packet also carries the full test.
        drive0(1, 1, 0, 0, 64'hD1);
        drive1(1, 1, 0, 0, 64'hE1);
        tick();
        check("tie2_rdy0", bus.src0_rdy, 1'b1);
        check("tie2_rdy1", bus.src1_rdy, 1'b0);
        drive1(0, 0, 0, 0, 64'h0);
        tick();
        check_out("full_d1", 64'hD1, 1, 0, 0);
        drive0(1, 0, 0, 0, 64'hD2);
        bus.pkt_tx_full = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_rdy_low%0d", i), bus.src0_rdy, 1'b0);
            tick();
            check($sformatf("full_no_val%0d", i), bus.pkt_tx_val, 1'b0);
        end
        bus.pkt_tx_full = 1'b0;
        #1;
        check("full_rdy_back", bus.src0_rdy, 1'b1);
        tick();
        check_out("full_d2", 64'hD2, 0, 0, 0);
        drive0(1, 0, 1, 7, 64'hD3);
        tick();
        check_out("full_d3", 64'hD3, 0, 1, 7);
        check("full_cnt0", pkt_cnt0, 16'd2);
        drive0(0, 0, 0, 0, 64'h0);

        // Orphan beats from source 1 are dropped, and the packet that follows is forwarded.
        drive1(1, 0, 0, 0, 64'hEE1);
        check("orph_rdy1", bus.src1_rdy, 1'b1);
        tick();
        check("orph_drop1", drop_cnt, 16'd1);
        check("orph_no_val", bus.pkt_tx_val, 1'b0);
        drive1(1, 0, 1, 0, 64'hEE2);
        tick();
        check("orph_drop2", drop_cnt, 16'd2);
        drive1(1, 1, 0, 0, 64'hF1);
        check("orph_req_rdy1", bus.src1_rdy, 1'b0);
        tick();
        tick();
        check_out("orph_f1", 64'hF1, 1, 0, 0);
        drive1(1, 0, 1, 2, 64'hF2);
        tick();
        check_out("orph_f2", 64'hF2, 0, 1, 2);
        check("orph_cnt1", pkt_cnt1, 16'd2);
        check("orph_drop_keep", drop_cnt, 16'd2);
        // Orphans from both sources in the same cycle add 2.
        drive0(1, 0, 0, 0, 64'h1);
        drive1(1, 0, 0, 0, 64'h2);
        tick();
        check("orph_drop_both", drop_cnt, 16'd4);
        drive0(0, 0, 0, 0, 64'h0);
        drive1(0, 0, 0, 0, 64'h0);

        // A sop in mid-packet sets proto_err, which stays set until clr_stats.
        drive0(1, 1, 0, 0, 64'h61);
        tick();
        tick();
        check_out("perr_g1", 64'h61, 1, 0, 0);
        check("perr_clean", proto_err, 1'b0);
        drive0(1, 1, 0, 0, 64'h62);
        tick();
        check_out("perr_g2", 64'h62, 1, 0, 0);
        check("perr_set", proto_err, 1'b1);
        drive0(1, 0, 1, 0, 64'h63);
        tick();
        check("perr_sticky", proto_err, 1'b1);
        check("perr_cnt0", pkt_cnt0, 16'd3);
        drive0(0, 0, 0, 0, 64'h0);
        tick();
        check("perr_sticky2", proto_err, 1'b1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_perr", proto_err, 1'b0);
        check("clr_cnt0", pkt_cnt0,  16'd0);
        check("clr_cnt1", pkt_cnt1,  16'd0);
        check("clr_drop", drop_cnt,  16'd0);

        // Reset in mid-packet abandons the packet, and source 0 wins the next tie.
        drive1(1, 1, 0, 0, 64'h71);
        tick();
        tick();
        check_out("rst_mid_h1", 64'h71, 1, 0, 0);
        drive1(0, 0, 0, 0, 64'h0);
        reset_156m25 = 1'b1;
        #1;
        check("rstm_val",  bus.pkt_tx_val,  1'b0);
        check("rstm_data", bus.pkt_tx_data, 64'h0);
        check("rstm_sop",  bus.pkt_tx_sop,  1'b0);
        check("rstm_rdy1", bus.src1_rdy,    1'b0);
        tick();
        reset_156m25 = 1'b0;
        drive0(1, 1, 0, 0, 64'h81);
        drive1(1, 1, 0, 0, 64'h91);
        tick();
        check("rstm_tie_rdy0", bus.src0_rdy, 1'b1);
        check("rstm_tie_rdy1", bus.src1_rdy, 1'b0);
        tick();
        check_out("rstm_tie_out", 64'h81, 1, 0, 0);
        check("rstm_no_eop", bus.pkt_tx_eop, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the MAC POS-L3 transmit interface (pkt_tx_*) between two packet sources.
- Sits between two sources (for example a test-traffic generator and a loopback/replay path) and the MAC core's pkt_tx port.
- Honours the MAC's pkt_tx_full backpressure.
- Keeps per-source packet counters and a protocol-drop counter, so the bench can check the sequencing.

Parameters:
- CNT_W, 16, width of every statistics counter (all counters saturate at 2^CNT_W-1).

Ports:
- clk_156m25  in  1  core clock; all logic on rising edge.
- reset_156m25  in  1  reset, asynchronous, active-high.
- src0_data  in  64  source 0 beat data.
- src0_sop  in  1  source 0 start of packet.
- src0_eop  in  1  source 0 end of packet.
- src0_mod  in  3  source 0 valid-byte modulus on the eop beat (0 = all 8 bytes).
- src0_val  in  1  source 0 beat valid.
- src0_rdy  out  1  source 0 beat accepted this cycle when src0_val=1.
- src1_data, src1_sop, src1_eop, src1_mod, src1_val  in  64/1/1/3/1  source 1, same meaning as source 0.
- src1_rdy  out  1  source 1 beat accepted this cycle when src1_val=1.
- pkt_tx_data  out  64  to MAC.
- pkt_tx_sop  out  1  to MAC.
- pkt_tx_eop  out  1  to MAC.
- pkt_tx_mod  out  3  to MAC.
- pkt_tx_val  out  1  to MAC.
- pkt_tx_full  in  1  MAC transmit FIFO full.
- pkt_cnt0  out  CNT_W  packets forwarded from source 0.
- pkt_cnt1  out  CNT_W  packets forwarded from source 1.
- drop_cnt  out  CNT_W  orphan beats discarded (both sources).
- proto_err  out  1  sticky: sop received mid-packet from the granted source.
- clr_stats  in  1  synchronous clear of the counters and proto_err.

Behaviour:
- Reset values: state IDLE, rr_last=1 (source 0 wins the first tie), all pkt_tx_* outputs 0, srcN_rdy 0, all counters 0, proto_err 0. Reset mid-packet abandons the packet; no eop is generated.
- The FSM has three states: IDLE, GNT0, GNT1.
- IDLE, request rule: a source requests when srcN_val=1 and srcN_sop=1.
- IDLE, single request: grant the requesting source; next state GNTn.
- IDLE, both requesting: grant the source that is not rr_last.
- IDLE, no beats accepted: srcN_rdy=0 for requesting sources. This gives one arbitration bubble per packet.
- IDLE, orphan beats: a source with val=1 and sop=0 has srcN_rdy=1 combinationally. The beat is discarded and drop_cnt increments by 1, or by 2 if both sources present orphans in the same cycle.
- GNTn, ready: srcN_rdy = !pkt_tx_full (combinational); the other source's rdy = 0.
- GNTn, accepted beat (val & rdy): data/sop/eop/mod are registered onto pkt_tx_* with pkt_tx_val=1 on the next cycle (latency 1). In cycles with no accepted beat, pkt_tx_val=0 and the data outputs hold their last value.
- GNTn, pkt_tx_full: while it is asserted, no beats are accepted. At most one beat already registered reaches the MAC after full rises; the MAC FIFO full threshold covers this.
- GNTn, end of packet: an accepted beat with eop=1 sends the FSM to IDLE, sets rr_last=n and increments pkt_cnt_n (saturating). A beat with sop=1 and eop=1 is a one-beat packet.
- GNTn, sop mid-packet: an accepted beat with sop=1 that is not the first beat of the packet sets proto_err and is forwarded unchanged.
- clr_stats: zeroes the counters and proto_err on the next edge. If clr_stats coincides with an increment, the clear wins.

Test Plan:
- Source 0 sends one 3-beat packet (mod=5 on eop), source 1 idle → src0_rdy first high the cycle after sop is presented; MAC sees val/sop, val, val/eop/mod=5 on consecutive cycles; pkt_cnt0=1.
- Both sources raise sop in the same cycle after reset → source 0 granted first. Its packet fully precedes source 1's packet with no interleaving. Final pkt_cnt0=1, pkt_cnt1=1, and the next tie goes to source 0 again.
- pkt_tx_full held high for 4 cycles mid-packet → src_rdy low for exactly those 4 cycles; at most 1 pkt_tx_val after full rises; data order preserved.
- Source 1 presents 2 non-sop beats in IDLE, then a valid packet → drop_cnt=2; the packet is forwarded intact.
- Granted source sends sop on its second beat → proto_err=1 and stays 1 until clr_stats; clr_stats then zeroes proto_err and all counters.
- Assert reset_156m25 mid-packet, then release → all outputs 0 immediately (asynchronous); the next sop is arbitrated from IDLE with source 0 preferred.
